// File: rtl/sru_multi_syn_trace.sv
// Synaptic response unit: four leaky traces (ES+/ES-, IS+/IS-) for one
// post-synaptic neuron. Each timestep decays every trace by its own shift,
// then walks the synapses in index order, adding the weight of each spiking
// synapse into the trace pair of its class.
//
// Handshake: step_start is a one-cycle request that is accepted only in IDLE
// (busy low); the spike, class and weight inputs are captured on that same
// edge. done is a one-cycle pulse when the traces are final for the step; a
// step_start seen while busy is dropped and recorded in the sticky overrun flag.
module sru_multi_syn_trace #(
   parameter int DATA_W   = 16,
   parameter int NUM_SYN  = 8,
   parameter int SHIFT_EP = 2,
   parameter int SHIFT_EN = 3,
   parameter int SHIFT_IP = 2,
   parameter int SHIFT_IN = 1,
   parameter int SAT_EN   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      step_start,
   input  logic [NUM_SYN-1:0]        spike_vec,
   input  logic [NUM_SYN-1:0]        exc_vec,
   input  logic [NUM_SYN*DATA_W-1:0] w_flat,
   input  logic                      clear,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_W-1:0]         es_plus,
   output logic [DATA_W-1:0]         es_minus,
   output logic [DATA_W-1:0]         is_plus,
   output logic [DATA_W-1:0]         is_minus,
   output logic                      sat_flag,
   output logic                      overrun,
   output logic [1:0]                state_dbg
);

   localparam int IDX_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DECAY = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NUM_SYN-1:0]        spk_q, spk_d;
   logic [NUM_SYN-1:0]        exc_q, exc_d;
   logic [NUM_SYN*DATA_W-1:0] w_q, w_d;
   logic [DATA_W-1:0]         ep_q, ep_d, em_q, em_d, ip_q, ip_d, im_q, im_d;
   logic                      sat_q, sat_d;
   logic                      ovr_q, ovr_d;

   logic [DATA_W-1:0]         cur_w;
   logic                      cur_spk;
   logic                      cur_exc;
   logic [DATA_W:0]           add_a;
   logic [DATA_W:0]           add_b;

   // Add at DATA_W+1 bits; returns {overflow, result}. With saturation the
   // result clamps to all ones, otherwise the carry is simply dropped.
   function automatic logic [DATA_W:0] trace_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[DATA_W] && (SAT_EN != 0)) begin
         trace_add = {1'b1, {DATA_W{1'b1}}};
      end else begin
         trace_add = sum;
      end
   endfunction

   // Select the shadowed spike, class and weight of the synapse being serviced.
   always_comb begin
      cur_w   = '0;
      cur_spk = 1'b0;
      cur_exc = 1'b0;
      for (int i = 0; i < NUM_SYN; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_w   = w_q[i*DATA_W +: DATA_W];
            cur_spk = spk_q[i];
            cur_exc = exc_q[i];
         end
      end
   end

   // Next-state, trace update and sticky flag logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      spk_d   = spk_q;
      exc_d   = exc_q;
      w_d     = w_q;
      ep_d    = ep_q;
      em_d    = em_q;
      ip_d    = ip_q;
      im_d    = im_q;
      sat_d   = sat_q;
      ovr_d   = ovr_q;
      add_a   = '0;
      add_b   = '0;

      case (state_q)
         ST_IDLE: begin
            if (step_start) begin
               spk_d   = spike_vec;
               exc_d   = exc_vec;
               w_d     = w_flat;
               state_d = ST_DECAY;
            end
         end
         ST_DECAY: begin
            // Truncating shift: a trace below 2^shift keeps its value.
            ep_d    = ep_q - (ep_q >> SHIFT_EP);
            em_d    = em_q - (em_q >> SHIFT_EN);
            ip_d    = ip_q - (ip_q >> SHIFT_IP);
            im_d    = im_q - (im_q >> SHIFT_IN);
            idx_d   = '0;
            state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (cur_spk) begin
               if (cur_exc) begin
                  add_a = trace_add(ep_q, cur_w);
                  add_b = trace_add(em_q, cur_w);
                  ep_d  = add_a[DATA_W-1:0];
                  em_d  = add_b[DATA_W-1:0];
               end else begin
                  add_a = trace_add(ip_q, cur_w);
                  add_b = trace_add(im_q, cur_w);
                  ip_d  = add_a[DATA_W-1:0];
                  im_d  = add_b[DATA_W-1:0];
               end
               if (add_a[DATA_W] || add_b[DATA_W]) begin
                  sat_d = 1'b1;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A request while busy is dropped but remembered.
      if (step_start && (state_q != ST_IDLE) && !clear) begin
         ovr_d = 1'b1;
      end

      // Clear aborts the step and wins over a same-cycle step_start; the
      // sticky flags survive it.
      if (clear) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         ep_d    = '0;
         em_d    = '0;
         ip_d    = '0;
         im_d    = '0;
      end
   end

   // State, shadow and trace registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         spk_q   <= '0;
         exc_q   <= '0;
         w_q     <= '0;
         ep_q    <= '0;
         em_q    <= '0;
         ip_q    <= '0;
         im_q    <= '0;
         sat_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         spk_q   <= spk_d;
         exc_q   <= exc_d;
         w_q     <= w_d;
         ep_q    <= ep_d;
         em_q    <= em_d;
         ip_q    <= ip_d;
         im_q    <= im_d;
         sat_q   <= sat_d;
         ovr_q   <= ovr_d;
      end
   end

   // Output decode from registered state.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      es_plus   = ep_q;
      es_minus  = em_q;
      is_plus   = ip_q;
      is_minus  = im_q;
      sat_flag  = sat_q;
      overrun   = ovr_q;
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_sru_multi_syn_trace.sv
// Bench for sru_multi_syn_trace: two instances share stimulus, one saturating
// and one wrapping. Driver tasks push hand-computed expectations; a monitor
// pops and compares whenever done pulses.
module tb_sru_multi_syn_trace;

   localparam int DW = 16;
   localparam int NS = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            step_start;
   logic [NS-1:0]   spike_vec;
   logic [NS-1:0]   exc_vec;
   logic [NS*DW-1:0] w_flat;
   logic            clear;

   logic            busy, done, sat_flag, overrun;
   logic [DW-1:0]   es_plus, es_minus, is_plus, is_minus;
   logic [1:0]      state_dbg;

   logic            busy_w, done_w, sat_flag_w, overrun_w;
   logic [DW-1:0]   es_plus_w, es_minus_w, is_plus_w, is_minus_w;
   logic [1:0]      state_dbg_w;

   sru_multi_syn_trace #(.DATA_W(DW), .NUM_SYN(NS), .SAT_EN(1)) dut (
      .clk(clk), .reset(reset), .step_start(step_start), .spike_vec(spike_vec),
      .exc_vec(exc_vec), .w_flat(w_flat), .clear(clear), .busy(busy), .done(done),
      .es_plus(es_plus), .es_minus(es_minus), .is_plus(is_plus), .is_minus(is_minus),
      .sat_flag(sat_flag), .overrun(overrun), .state_dbg(state_dbg)
   );

   sru_multi_syn_trace #(.DATA_W(DW), .NUM_SYN(NS), .SAT_EN(0)) dut_w (
      .clk(clk), .reset(reset), .step_start(step_start), .spike_vec(spike_vec),
      .exc_vec(exc_vec), .w_flat(w_flat), .clear(clear), .busy(busy_w), .done(done_w),
      .es_plus(es_plus_w), .es_minus(es_minus_w), .is_plus(is_plus_w), .is_minus(is_minus_w),
      .sat_flag(sat_flag_w), .overrun(overrun_w), .state_dbg(state_dbg_w)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] ep, em, ip, im, ep_w;
      logic          sat, sat_w;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("es_plus", es_plus, e.ep);
            chk("es_minus", es_minus, e.em);
            chk("is_plus", is_plus, e.ip);
            chk("is_minus", is_minus, e.im);
            chk("sat_flag", sat_flag, e.sat);
            chk("wrap_done", done_w, 1);
            chk("wrap_es_plus", es_plus_w, e.ep_w);
            chk("wrap_sat_flag", sat_flag_w, e.sat_w);
         end
      end
   end

   // Driver tasks
   task automatic issue(input logic [NS-1:0] spk, input logic [NS-1:0] exc,
                        input logic [NS*DW-1:0] w, input logic push,
                        input logic [DW-1:0] ep, input logic [DW-1:0] em,
                        input logic [DW-1:0] ip, input logic [DW-1:0] im,
                        input logic [DW-1:0] ep_w, input logic sat, input logic sat_w);
      exp_t e;
      @(negedge clk);
      spike_vec  = spk;
      exc_vec    = exc;
      w_flat     = w;
      step_start = 1'b1;
      if (push) begin
         e.ep = ep; e.em = em; e.ip = ip; e.im = im; e.ep_w = ep_w;
         e.sat = sat; e.sat_w = sat_w;
         e.cyc = cyc + NS + 2;
         exp_q.push_back(e);
      end
      @(negedge clk);
      step_start = 1'b0;
      // Scramble the inputs: the step must use the captured copies.
      spike_vec  = NS'($urandom_range(15, 0));
      exc_vec    = NS'($urandom_range(15, 0));
      w_flat     = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !busy) break;
      end
      chk("step_timeout", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; step_start = 1'b0; clear = 1'b0;
      spike_vec = '0; exc_vec = '0; w_flat = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_es_plus", es_plus, 0);
      chk("rst_es_minus", es_minus, 0);
      chk("rst_is_plus", is_plus, 0);
      chk("rst_is_minus", is_minus, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_overrun", overrun, 0);

      // Excitatory spike on syn0, then an empty step (decay only)
      issue(4'b0001, 4'b0001, 64'd100, 1, 16'd100, 16'd100, 16'd0, 16'd0, 16'd100, 0, 0);
      wait_idle();
      issue(4'b0000, 4'b0000, 64'd0, 1, 16'd75, 16'd88, 16'd0, 16'd0, 16'd75, 0, 0);
      wait_idle();

      // Inhibitory spike on syn2 from cleared traces, then decay
      do_clear();
      issue(4'b0100, 4'b0000, {16'd0, 16'd64, 16'd0, 16'd0}, 1,
            16'd0, 16'd0, 16'd64, 16'd64, 16'd0, 0, 0);
      wait_idle();
      issue(4'b0000, 4'b0000, 64'd0, 1, 16'd0, 16'd0, 16'd48, 16'd32, 16'd0, 0, 0);
      wait_idle();

      // Second step_start two cycles into a step
      do_clear();
      issue(4'b0011, 4'b0011, {16'd0, 16'd0, 16'd7, 16'd5}, 1,
            16'd12, 16'd12, 16'd0, 16'd0, 16'd12, 0, 0);
      @(negedge clk);
      spike_vec = 4'b1111; exc_vec = 4'b1111; w_flat = {4{16'hFFFF}};
      step_start = 1'b1;
      @(negedge clk);
      step_start = 1'b0;
      wait_idle();
      chk("overrun", overrun, 1);
      chk("wrap_overrun", overrun_w, 1);

      // All four excitatory at full scale: clamp vs wrap
      do_clear();
      issue(4'b1111, 4'b1111, {4{16'hFFFF}}, 1,
            16'd65535, 16'd65535, 16'd0, 16'd0, 16'd65532, 1, 1);
      wait_idle();
      do_clear();
      chk("sat_kept_after_clear", sat_flag, 1);
      chk("clear_es_plus", es_plus, 0);

      // Asynchronous reset during ACCUM at idx 2
      issue(4'b1111, 4'b1111, {4{16'd1}}, 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0);
      repeat (3) @(negedge clk);
      chk("pre_reset_es_plus", es_plus, 2);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_es_plus", es_plus, 0);
      chk("mid_rst_es_minus", es_minus, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_sat_flag", sat_flag, 0);
      chk("mid_rst_overrun", overrun, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      issue(4'b0010, 4'b0010, {16'd0, 16'd0, 16'd10, 16'd0}, 1,
            16'd10, 16'd10, 16'd0, 16'd0, 16'd10, 0, 0);
      wait_idle();

      // Small trace below 2^shift survives the decay unchanged
      do_clear();
      issue(4'b0001, 4'b0001, 64'd3, 1, 16'd3, 16'd3, 16'd0, 16'd0, 16'd3, 0, 0);
      wait_idle();
      issue(4'b0000, 4'b0000, 64'd0, 1, 16'd3, 16'd3, 16'd0, 16'd0, 16'd3, 0, 0);
      wait_idle();

      repeat (10) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sru_multi_syn_trace.md
Name: sru_multi_syn_trace

Overview:
- Parametrised synaptic response unit for one post-synaptic neuron with NUM_SYN input synapses.
- Maintains four leaky traces: ES_plus, ES_minus (excitatory) and IS_plus, IS_minus (inhibitory).
- Each trace decays by its own parametrised right-shift once per timestep.
- After the decay, the unit adds the weights of all spiking synapses, one synapse per clock, into the traces of that synapse's class. Saturation is optional.
- Sits between the spike-input crossbar and the neuron membrane-update stage.

Parameters:
- DATA_W, 16, trace and weight width in bits.
- NUM_SYN, 8, number of synapses serviced per timestep (≥1).
- SHIFT_EP, 2, decay shift for ES_plus.
- SHIFT_EN, 3, decay shift for ES_minus.
- SHIFT_IP, 2, decay shift for IS_plus.
- SHIFT_IN, 1, decay shift for IS_minus.
- SAT_EN, 1, 1 = saturate additions at 2^DATA_W-1; 0 = wrap modulo 2^DATA_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- step_start  in  1  one-cycle pulse that starts a timestep.
- spike_vec  in  NUM_SYN  spike bit per synapse; sampled only on an accepted step_start.
- exc_vec  in  NUM_SYN  class per synapse: 1 = excitatory, 0 = inhibitory; sampled with spike_vec.
- w_flat  in  NUM_SYN*DATA_W  packed weights; synapse i occupies bits [i*DATA_W +: DATA_W]; sampled with spike_vec.
- clear  in  1  synchronous trace clear and abort.
- busy  out  1  high in DECAY, ACCUM and DONE.
- done  out  1  one-cycle pulse; traces are final for the step.
- es_plus, es_minus, is_plus, is_minus  out  DATA_W each  registered traces.
- sat_flag  out  1  sticky: set when any addition saturated (SAT_EN=1) or wrapped (SAT_EN=0).
- overrun  out  1  sticky: set when step_start arrives while busy.

Behaviour:
- Reset (asynchronous, any state): all traces 0, sat_flag 0, overrun 0, busy 0, done 0, synapse index 0, FSM to IDLE.
- FSM states: IDLE, DECAY, ACCUM, DONE.
- IDLE, step_start=1: latch spike_vec, exc_vec and w_flat into shadow registers; go to DECAY. Later changes to the inputs do not affect the step.
- DECAY (1 cycle): every trace t becomes t - (t >> SHIFT_x) with its own shift; set idx=0; go to ACCUM.
  - Truncating floor: a trace below 2^SHIFT_x does not change, e.g. es_plus=3 stays 3.
- ACCUM (NUM_SYN cycles): one synapse per cycle, in index order 0..NUM_SYN-1.
  - Spiking excitatory synapse: add its weight to es_plus and es_minus.
  - Spiking inhibitory synapse: add its weight to is_plus and is_minus.
  - Non-spiking synapse: no change.
  - After idx=NUM_SYN-1, go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- Latency: step_start sampled at edge E0 gives done high in the cycle after edge E(NUM_SYN+1), i.e. NUM_SYN+2 cycles after the step_start cycle.
- Traces change only in DECAY and ACCUM. They hold from DONE until the next accepted step.
- Arithmetic: each addition is performed at DATA_W+1 bits.
  - SAT_EN=1: a result of 2^DATA_W or more clamps to 2^DATA_W-1 and sets sat_flag.
  - SAT_EN=0: the result is truncated to DATA_W bits and sat_flag is set on carry-out.
- step_start while busy: ignored, overrun set, current step continues unchanged.
- clear in any state: all traces 0, FSM to IDLE, no done pulse. clear has priority over step_start in the same cycle. sat_flag and overrun are kept; only reset clears them.
- Reset mid-step: step abandoned, no done pulse. The next step_start after reset deasserts behaves normally.

Test Plan (DATA_W=16, NUM_SYN=4, default shifts):
- Reset, then idle 5 cycles -> all traces 0; busy, done, sat_flag, overrun all 0.
- Syn0 excitatory, w=100, spike; step_start -> done 6 cycles after the step_start cycle, es_plus=100, es_minus=100. Then a step with no spikes -> es_plus=75, es_minus=88, is_* = 0.
- Syn2 inhibitory, w=64, spike, one step; then a step with no spikes -> is_plus=48, is_minus=32, es_* unchanged.
- All four synapses excitatory, w=0xFFFF, all spiking, from zero traces:
  - SAT_EN=1 -> es_plus=65535, sat_flag=1.
  - SAT_EN=0 -> es_plus=65532, sat_flag=1.
- step_start pulsed again 2 cycles into a step -> overrun=1; a single done at the original time; traces reflect only the first step.
- Reset asserted asynchronously during ACCUM at idx=2 -> all outputs 0 immediately, no done. After reset release, a step with syn1 excitatory w=10 -> es_plus=10. Separately: es_plus=3 and an empty step -> es_plus stays 3.
